// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared state encoding and mode constants for the sequence detector
package seq_detect_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  localparam logic MODE_PATTERN = 1'b0;
  localparam logic MODE_RUN     = 1'b1;

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// rtl/seq_detect_param_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // A clear on the same edge as an event keeps that event, so the count restarts at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - configurable serial pattern / run detector with saturating match count
module seq_detect_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_mode,
  input  logic             cfg_overlap,
  input  logic             count_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);
  import seq_detect_pkg::*;

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  state_t           state;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] pat_q;
  logic             mode_q;
  logic             overlap_q;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_next;
  logic             accept;
  logic             hit;

  // The match is judged on the history as it will be after this edge, giving zero-latency pulses.
  always_comb begin
    hist_next = (hist << 1) | PAT_W'(in_bit);
    fill_next = (fill == FULL) ? FULL : fill + 1'b1;
    accept    = in_valid && !cfg_load && (state != UNCFG);
    hit       = 1'b0;
    if (accept && (fill_next == FULL)) begin
      if (mode_q == MODE_RUN) begin
        hit = (hist_next == '0) || (hist_next == '1);
      end else begin
        hit = (hist_next == pat_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= UNCFG;
      hist      <= '0;
      fill      <= '0;
      pat_q     <= '0;
      mode_q    <= MODE_PATTERN;
      overlap_q <= 1'b0;
      match     <= 1'b0;
    end else begin
      match <= hit;
      if (cfg_load) begin
        pat_q     <= cfg_pattern;
        mode_q    <= cfg_mode;
        overlap_q <= cfg_overlap;
        fill      <= '0;
        state     <= FILL;
      end else if (accept) begin
        hist <= hist_next;
        if (hit && !overlap_q) begin
          fill  <= '0;
          state <= FILL;
        end else begin
          fill <= fill_next;
          if (fill_next == FULL) begin
            state <= ARMED;
          end
        end
      end
    end
  end

  assign armed = (state == ARMED);

  sat_counter #(.W(CNT_W)) u_count (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (count_clr),
    .q   (match_count)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - self-checking bench for seq_detect_param
module tb_seq_detect_param;

  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_bit, cfg_load, cfg_mode, cfg_overlap, count_clr;
  logic [PW-1:0] cfg_pattern;
  logic          match, armed, match_s, armed_s;
  logic [7:0]    match_count;
  logic [1:0]    match_count_s;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit       q[$];
  bit       configured;
  bit [3:0] mpat;
  bit       mmode, movl;
  int       c8, c2;
  bit       exp_match, exp_armed;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(PW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mode(cfg_mode),
    .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .match(match), .match_count(match_count), .armed(armed)
  );

  seq_detect_param #(.PAT_W(PW), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mode(cfg_mode),
    .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .match(match_s), .match_count(match_count_s), .armed(armed_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".match"}, 32'(match), 32'(exp_match));
    check({tag, ".count"}, 32'(match_count), 32'(c8));
    check({tag, ".armed"}, 32'(armed), 32'(exp_armed));
    check({tag, ".match_s"}, 32'(match_s), 32'(exp_match));
    check({tag, ".count_s"}, 32'(match_count_s), 32'(c2));
  endtask

  // Rules applied directly: remember the accepted bits since the last restart, look at the newest window.
  task automatic model_edge();
    bit [3:0] w;
    exp_match = 1'b0;
    if (cfg_load) begin
      configured = 1'b1;
      mpat  = cfg_pattern;
      mmode = cfg_mode;
      movl  = cfg_overlap;
      q.delete();
    end else if (configured && in_valid) begin
      q.push_back(in_bit);
      if (q.size() > PW) void'(q.pop_front());
      if (q.size() == PW) begin
        for (int i = 0; i < PW; i++) w[i] = q[PW-1-i];
        exp_match = mmode ? (w == 4'h0 || w == 4'hF) : (w == mpat);
        if (exp_match && !movl) q.delete();
      end
    end
    if (count_clr) begin
      c8 = int'(exp_match);
      c2 = int'(exp_match);
    end else if (exp_match) begin
      if (c8 < 255) c8++;
      if (c2 < 3) c2++;
    end
    exp_armed = configured && (q.size() == PW);
  endtask

  task automatic step(input logic v, input logic b, input logic ld, input logic [3:0] pat,
                      input logic md, input logic ov, input logic cl, input string tag);
    @(negedge clk);
    in_valid = v; in_bit = b; cfg_load = ld; cfg_pattern = pat;
    cfg_mode = md; cfg_overlap = ov; count_clr = cl;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic feed(input logic v, input logic b, input string tag);
    step(v, b, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic load(input logic [3:0] pat, input logic md, input logic ov);
    step(1'b1, 1'b1, 1'b1, pat, md, ov, 1'b1, "load");
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    configured = 1'b0; q.delete(); c8 = 0; c2 = 0; exp_match = 0; exp_armed = 0;
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_bits(input logic [31:0] bits, input int n, input string tag,
                          output logic [31:0] mvec, output logic [31:0] avec);
    mvec = '0; avec = '0;
    for (int i = 0; i < n; i++) begin
      feed(1'b1, bits[i], tag);
      mvec[i] = match;
      avec[i] = armed;
    end
  endtask

  logic [31:0] mv, av;
  int          gap_hits;

  initial begin
    rst = 1'b1; in_valid = 0; in_bit = 0; cfg_load = 0; cfg_pattern = '0;
    cfg_mode = 0; cfg_overlap = 0; count_clr = 0;
    do_reset("reset");

    // Unconfigured: bits ignored.
    run_bits(32'h1F, 5, "uncfg", mv, av);
    check("uncfg.mvec", mv, 32'h0);
    check("uncfg.count", 32'(match_count), 32'h0);
    check("uncfg.armed", av, 32'h0);

    // Pattern 1011, oldest first 1,0,1,1; stream 1,0,1,1,0,1,1 (bits given LSB-first in time).
    load(4'b1011, 1'b0, 1'b1);
    run_bits(32'b1101101, 7, "pat_ovl", mv, av);
    check("pat_ovl.mvec", mv, 32'b1001000);
    check("pat_ovl.count", 32'(match_count), 32'd2);

    load(4'b1011, 1'b0, 1'b0);
    run_bits(32'b1101101, 7, "pat_novl", mv, av);
    check("pat_novl.mvec", mv, 32'b0001000);
    check("pat_novl.count", 32'(match_count), 32'd1);
    check("pat_novl.armed4", 32'(av[3]), 32'd0);

    load(4'b0000, 1'b1, 1'b1);
    run_bits(32'b00000, 5, "run0", mv, av);
    check("run0.mvec", mv, 32'b11000);
    load(4'b0000, 1'b1, 1'b0);
    run_bits(32'hFF, 8, "run1", mv, av);
    check("run1.mvec", mv, 32'b10001000);

    // Gaps between accepted bits 2 and 3.
    load(4'b1011, 1'b0, 1'b1);
    mv = '0; gap_hits = 0;
    feed(1'b1, 1'b1, "gap"); mv[0] = match;
    feed(1'b1, 1'b0, "gap"); mv[1] = match;
    for (int i = 0; i < 3; i++) begin
      feed(1'b0, 1'b1, "gap_idle");
      gap_hits += int'(match);
    end
    feed(1'b1, 1'b1, "gap"); mv[2] = match;
    feed(1'b1, 1'b1, "gap"); mv[3] = match;
    feed(1'b1, 1'b0, "gap"); mv[4] = match;
    feed(1'b1, 1'b1, "gap"); mv[5] = match;
    feed(1'b1, 1'b1, "gap"); mv[6] = match;
    check("gap.mvec", mv, 32'b1001000);
    check("gap.idle_pulses", 32'(gap_hits), 32'd0);

    // Saturation with six matches, then clear coincident with a match, then clear alone.
    load(4'b0000, 1'b1, 1'b1);
    run_bits(32'h0, 9, "sat", mv, av);
    check("sat.count_s", 32'(match_count_s), 32'd3);
    check("sat.count", 32'(match_count), 32'd6);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "clr_hit");
    check("clr_hit.count_s", 32'(match_count_s), 32'd1);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "clr_only");
    check("clr_only.count", 32'(match_count), 32'd0);

    // Reset mid-fill discards progress; no match until reconfigured.
    load(4'b1111, 1'b0, 1'b1);
    feed(1'b1, 1'b1, "prefill");
    feed(1'b1, 1'b1, "prefill");
    do_reset("rst_fill");
    run_bits(32'h3F, 6, "post_rst", mv, av);
    check("post_rst.mvec", mv, 32'h0);
    check("post_rst.armed", av, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 39) == 0,
             4'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 49) == 0, "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
